// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time against a synchronous word array.
// Sub-word stores use read-modify-write; loads are lane-aligned and extended per funct3.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int          ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN   = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t             r_state;
  logic [31:0]        r_mem [DEPTH_WORDS];
  logic [31:0]        r_rdWord;
  logic [31:0]        r_wdata;
  logic               r_write;
  logic [2:0]         r_funct3;
  logic [1:0]         r_lane;
  logic [ADDR_W-1:0]  r_index;
  logic [31:0]        r_rspRdata;
  logic               r_rspError;

  logic [31:0]        w_off;
  logic [1:0]         w_lane;
  logic [ADDR_W-1:0]  w_index;
  logic               w_inRange;
  logic               w_legal;
  logic               w_misaligned;
  logic               w_error;
  logic               w_accept;
  logic               w_isSw;
  logic               w_memWe;
  logic               w_memRe;
  logic [ADDR_W-1:0]  w_memWaddr;
  logic [31:0]        w_memWdata;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_loadData;
  logic [31:0]        w_mask;
  logic [31:0]        w_merged;

  // Offset arithmetic wraps, so addresses below BASE_ADDR land far out of range.
  assign w_off     = req_addr - BASE_ADDR;
  assign w_lane    = w_off[1:0];
  assign w_index   = w_off[ADDR_W+1:2];
  assign w_inRange = (w_off < SPAN);
  assign w_accept  = req_valid && (r_state == IDLE);
  assign w_isSw    = req_write && (req_funct3 == 3'b010);

  always_comb begin
    w_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = !req_write;
      default:                w_legal = 1'b0;
    endcase
  end

  assign w_misaligned = ((req_funct3[1:0] == 2'b01) && w_lane[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (w_lane != 2'b00));
  assign w_error      = !w_legal || w_misaligned || !w_inRange;

  always_comb begin
    w_byte     = r_rdWord[{r_lane, 3'b000} +: 8];
    w_half     = r_rdWord[{r_lane[1], 4'b0000} +: 16];
    w_loadData = r_rdWord;
    case (r_funct3)
      3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
      3'b100:  w_loadData = {24'h0, w_byte};
      3'b101:  w_loadData = {16'h0, w_half};
      default: w_loadData = r_rdWord;
    endcase
    w_mask   = (r_funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << {r_lane, 3'b000};
    w_merged = (r_rdWord & ~w_mask) | ((r_wdata << {r_lane, 3'b000}) & w_mask);
  end

  // Array writes come from an SW accept or the sub-word write-back leaving READ;
  // reset low suppresses both.
  assign w_memWe    = reset && ((w_accept && !w_error && w_isSw) ||
                                ((r_state == READ) && r_write));
  assign w_memRe    = w_accept && !w_error && !w_isSw;
  assign w_memWaddr = (r_state == READ) ? r_index : w_index;
  assign w_memWdata = (r_state == READ) ? w_merged : req_wdata;

  always_ff @(posedge clock) begin
    if (w_memWe)
      r_mem[w_memWaddr] <= w_memWdata;
    if (w_memRe)
      r_rdWord <= r_mem[w_index];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_rspRdata <= 32'h0;
      r_rspError <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_funct3 <= req_funct3;
            r_lane   <= w_lane;
            r_index  <= w_index;
            r_wdata  <= req_wdata;
            if (w_error) begin
              r_rspError <= 1'b1;
              r_rspRdata <= 32'h0;
              r_state    <= RESP;
            end else if (w_isSw) begin
              r_rspError <= 1'b0;
              r_rspRdata <= 32'h0;
              r_state    <= RESP;
            end else begin
              r_state <= READ;
            end
          end
        end
        READ: begin
          r_rspError <= 1'b0;
          r_rspRdata <= r_write ? 32'h0 : w_loadData;
          r_state    <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rspRdata;
  assign rsp_error = r_rspError;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder, checked against a word-array reference model
// that applies the access rules directly with plain arithmetic.
module tb_dmem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0100_0000;

  typedef struct packed {
    logic        write;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } reqT;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  int          vectorCount = 0;
  int          miscompareCount = 0;
  logic [31:0] modelMem [DEPTH];
  bit          known [DEPTH];
  logic [31:0] lastRdata;

  always #5 clock = ~clock;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic reqT mkReq(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    reqT r;
    r.write = w; r.f3 = f3; r.addr = a; r.wdata = d;
    return r;
  endfunction

  // Reference model: predicts the response and updates modelMem as the access would.
  function automatic void predict(input reqT r, output bit err, output bit chk,
                                  output logic [31:0] rdata, output int lat);
    logic [31:0] off;
    logic [31:0] val;
    longint      mask;
    int          lane, size, idx;
    bit          legal;
    off   = r.addr - BASE;
    lane  = int'(off[1:0]);
    legal = r.write ? (r.f3 <= 3'd2) : (r.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << r.f3[1:0];
    err   = !legal || ((lane % size) != 0) || (off >= 32'(DEPTH * 4));
    rdata = 32'h0;
    chk   = 1'b1;
    lat   = 2;
    if (err) begin
      lat = 1;
      return;
    end
    idx = int'(off / 4);
    if (r.write) begin
      if (size == 4) begin
        lat = 1;
        modelMem[idx] = r.wdata;
        known[idx] = 1'b1;
      end else begin
        mask = ((64'd1 << (8 * size)) - 1) << (8 * lane);
        modelMem[idx] = (modelMem[idx] & ~mask[31:0]) | ((r.wdata << (8 * lane)) & mask[31:0]);
      end
    end else begin
      chk = known[idx];
      val = modelMem[idx] >> (8 * lane);
      if (size == 1) begin
        val = val & 32'hFF;
        if (!r.f3[2] && val >= 128) val = val - 256;
      end else if (size == 2) begin
        val = val & 32'hFFFF;
        if (!r.f3[2] && val >= 32768) val = val - 65536;
      end
      rdata = val;
    end
  endfunction

  task automatic drive(input reqT r);
    req_valid  = 1'b1;
    req_write  = r.write;
    req_funct3 = r.f3;
    req_addr   = r.addr;
    req_wdata  = r.wdata;
  endtask

  // Issues one request from a negedge; with hold set, the next request is put on
  // the bus right after accept with req_valid kept high.
  task automatic applyStimulus(input reqT r, input bit hold, input reqT nxt);
    bit          err, chk;
    logic [31:0] expData;
    int          lat, n;
    drive(r);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      checkOutput("acceptTimeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    predict(r, err, chk, expData, lat);
    @(posedge clock);
    #1;
    if (hold) drive(nxt);
    else begin
      req_valid  = 1'b0;
      req_write  = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
    end
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (!rsp_valid) checkOutput("readyBusy", 32'(req_ready), 32'd0);
    end while (!rsp_valid && n < 6);
    checkOutput("latency", 32'(n), 32'(lat));
    if (rsp_valid) begin
      checkOutput("readyResp", 32'(req_ready), 32'd0);
      checkOutput("error", 32'(rsp_error), 32'(err));
      if (chk) checkOutput("rdata", rsp_rdata, expData);
      lastRdata = rsp_rdata;
    end
    @(negedge clock);
    checkOutput("strobeOnce", 32'(rsp_valid), 32'd0);
    checkOutput("readyIdle", 32'(req_ready), 32'd1);
  endtask

  function automatic reqT genReq();
    logic [31:0] a;
    int          pick;
    pick = $urandom_range(0, 9);
    if (pick == 0)      a = BASE - 32'($urandom_range(1, 64));
    else if (pick == 1) a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 64));
    else if (pick == 2) a = BASE + 32'((DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
    else                a = BASE + 32'($urandom_range(0, 63));
    return mkReq(1'($urandom), 3'($urandom), a, $urandom);
  endfunction

  initial begin
    reqT q [4];
    reqT cur, nxt;
    reqT none;
    bit  hold;
    none = '0;
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clock);
    checkOutput("rstReady", 32'(req_ready), 32'd1);
    checkOutput("rstValid", 32'(rsp_valid), 32'd0);
    checkOutput("rstRdata", rsp_rdata, 32'h0);
    checkOutput("rstError", 32'(rsp_error), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    for (int w = 0; w < 16; w++)
      applyStimulus(mkReq(1'b1, 3'b010, BASE + 32'(w * 4), $urandom), 1'b0, none);
    applyStimulus(mkReq(1'b1, 3'b010, BASE + 32'((DEPTH - 1) * 4), $urandom), 1'b0, none);

    applyStimulus(mkReq(1'b1, 3'b010, BASE + 8, 32'hDEADBEEF), 1'b0, none);
    applyStimulus(mkReq(1'b0, 3'b010, BASE + 8, 32'h0), 1'b0, none);
    checkOutput("planLw", lastRdata, 32'hDEADBEEF);
    applyStimulus(mkReq(1'b1, 3'b000, BASE + 9, 32'hAAAAAA7F), 1'b0, none);
    applyStimulus(mkReq(1'b0, 3'b010, BASE + 8, 32'h0), 1'b0, none);
    checkOutput("planSb", lastRdata, 32'hDEAD7FEF);
    applyStimulus(mkReq(1'b0, 3'b000, BASE + 11, 32'h0), 1'b0, none);
    checkOutput("planLb", lastRdata, 32'hFFFFFFDE);
    applyStimulus(mkReq(1'b0, 3'b100, BASE + 11, 32'h0), 1'b0, none);
    checkOutput("planLbu", lastRdata, 32'h000000DE);

    applyStimulus(mkReq(1'b1, 3'b010, BASE + 4, 32'h11223344), 1'b0, none);
    applyStimulus(mkReq(1'b1, 3'b001, BASE + 6, 32'h12348001), 1'b0, none);
    applyStimulus(mkReq(1'b0, 3'b010, BASE + 4, 32'h0), 1'b0, none);
    checkOutput("planSh", lastRdata, 32'h80013344);
    applyStimulus(mkReq(1'b0, 3'b001, BASE + 6, 32'h0), 1'b0, none);
    checkOutput("planLh", lastRdata, 32'hFFFF8001);
    applyStimulus(mkReq(1'b0, 3'b101, BASE + 6, 32'h0), 1'b0, none);
    checkOutput("planLhu", lastRdata, 32'h00008001);

    applyStimulus(mkReq(1'b0, 3'b010, BASE + 2, 32'h0), 1'b0, none);
    applyStimulus(mkReq(1'b1, 3'b001, BASE + 1, 32'hFFFFFFFF), 1'b0, none);
    applyStimulus(mkReq(1'b0, 3'b010, BASE + 32'(DEPTH * 4), 32'h0), 1'b0, none);
    applyStimulus(mkReq(1'b0, 3'b010, BASE - 4, 32'h0), 1'b0, none);
    applyStimulus(mkReq(1'b0, 3'b011, BASE + 8, 32'h0), 1'b0, none);
    applyStimulus(mkReq(1'b1, 3'b011, BASE + 8, 32'h0), 1'b0, none);
    applyStimulus(mkReq(1'b1, 3'b100, BASE + 8, 32'h0), 1'b0, none);
    applyStimulus(mkReq(1'b0, 3'b010, BASE + 8, 32'h0), 1'b0, none);
    checkOutput("errUntouched", lastRdata, 32'hDEAD7FEF);
    applyStimulus(mkReq(1'b0, 3'b010, BASE + 32'((DEPTH - 1) * 4), 32'h0), 1'b0, none);

    // SB killed by reset while in READ: no write-back and no response.
    drive(mkReq(1'b1, 3'b000, BASE + 13, 32'h000000AB));
    @(posedge clock);
    #1;
    reset = 1'b0;
    req_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checkOutput("rstReadReady", 32'(req_ready), 32'd1);
    checkOutput("rstReadValid", 32'(rsp_valid), 32'd0);
    checkOutput("rstReadRdata", rsp_rdata, 32'h0);
    checkOutput("rstReadError", 32'(rsp_error), 32'd0);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clock);
      checkOutput("rstNoStrobe", 32'(rsp_valid), 32'd0);
    end
    applyStimulus(mkReq(1'b0, 3'b010, BASE + 12, 32'h0), 1'b0, none);

    // SW accepted on the same edge reset is low must not write.
    drive(mkReq(1'b1, 3'b010, BASE + 16, 32'h5A5A5A5A));
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    req_valid = 1'b0;
    @(negedge clock);
    checkOutput("rstSwValid", 32'(rsp_valid), 32'd0);
    applyStimulus(mkReq(1'b0, 3'b010, BASE + 16, 32'h0), 1'b0, none);

    q[0] = mkReq(1'b1, 3'b010, BASE + 20, 32'hCAFEF00D);
    q[1] = mkReq(1'b0, 3'b010, BASE + 20, 32'h0);
    q[2] = mkReq(1'b1, 3'b000, BASE + 21, 32'h00000055);
    q[3] = mkReq(1'b0, 3'b010, BASE + 20, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(q[i], 1'b1, q[i+1]);
    applyStimulus(q[3], 1'b0, none);
    checkOutput("heldSeq", lastRdata, 32'hCAFE550D);

    cur = genReq();
    for (int i = 0; i < 250; i++) begin
      nxt  = genReq();
      hold = 1'($urandom);
      applyStimulus(cur, hold, nxt);
      cur = nxt;
    end
    applyStimulus(cur, 1'b0, none);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
